// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit seven-segment scan path.
package display_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  typedef enum logic [1:0] {IDLE, GUARD, SHOW} scan_state_t;
  typedef logic [1:0] digit_idx_t;

  // Active-low anode pattern selecting a single digit.
  function automatic logic [NUM_DIGITS-1:0] anode_sel_n(input digit_idx_t d);
    return ~(4'b0001 << d);
  endfunction
endpackage

// File: rtl/lz_blank_mask.sv
// Per-digit visibility: digit enable combined with optional leading-zero blanking.
module lz_blank_mask
  import display_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic                    i_lz_blank,
  output logic [NUM_DIGITS-1:0]   o_visible
);
  logic [NUM_DIGITS-1:0] w_nz_above;

  // w_nz_above[i]: nibble i or any more-significant nibble is non-zero.
  always_comb begin
    w_nz_above = '0;
    w_nz_above[NUM_DIGITS-1] = |i_value[4*NUM_DIGITS-1 -: 4];
    for (int i = NUM_DIGITS-2; i >= 0; i--)
      w_nz_above[i] = w_nz_above[i+1] | (|i_value[4*i +: 4]);
  end

  always_comb begin
    o_visible = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      o_visible[i] = i_digit_en[i] & ((i == 0) | ~i_lz_blank | w_nz_above[i]);
  end
endmodule

// File: rtl/display_scan_controller.sv
// Digit scan scheduler: guard/on-time slots per digit, frame-latched value,
// registered active-low anode and decimal-point outputs.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] hex_num_4digit,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [1:0]  digit,
  output logic [15:0] shown_num,
  output logic [3:0]  anode,
  output logic        dp_n,
  output logic        frame_tick
);
  localparam int             CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  GUARD_LAST = CW'(BLANK_CYCLES - 1);

  scan_state_t   r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  digit_idx_t    r_digit, w_ndigit;
  logic [15:0]   r_shown, w_nshown;
  logic [3:0]    r_anode, w_nanode;
  logic          r_dp_n, w_ndp_n;
  logic          r_tick, w_ntick;
  logic [3:0]    w_visible;

  lz_blank_mask u_mask (
    .i_value    (r_shown),
    .i_digit_en (digit_en),
    .i_lz_blank (lz_blank),
    .o_visible  (w_visible)
  );

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_ndigit = r_digit;
    w_nshown = r_shown;
    w_ntick  = 1'b0;
    unique case (r_state)
      IDLE: if (en) begin
        w_nstate = GUARD;
        w_ncnt   = '0;
        w_ndigit = '0;
        w_nshown = hex_num_4digit;
        w_ntick  = 1'b1;
      end
      GUARD: begin
        w_ncnt = r_cnt + 1'b1;
        if (r_cnt == GUARD_LAST) w_nstate = SHOW;
      end
      SHOW: begin
        if (r_cnt == CNT_LAST) begin
          w_ncnt   = '0;
          w_ndigit = r_digit + 1'b1;
          w_nstate = GUARD;
          // Frame boundary: latch the new value so a frame never tears.
          if (r_digit == 2'd3) begin
            w_nshown = hex_num_4digit;
            w_ntick  = 1'b1;
          end
        end else begin
          w_ncnt = r_cnt + 1'b1;
        end
      end
      default: w_nstate = IDLE;
    endcase

    // Disable overrides any slot or frame advance.
    if (!en) begin
      w_nstate = IDLE;
      w_ncnt   = '0;
      w_ndigit = '0;
      w_nshown = r_shown;
      w_ntick  = 1'b0;
    end

    w_nanode = ANODES_OFF;
    w_ndp_n  = 1'b1;
    if (w_nstate == SHOW && w_visible[w_ndigit]) begin
      w_nanode = anode_sel_n(w_ndigit);
      w_ndp_n  = ~dp_in[w_ndigit];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_digit <= '0;
      r_shown <= '0;
      r_anode <= ANODES_OFF;
      r_dp_n  <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_digit <= w_ndigit;
      r_shown <= w_nshown;
      r_anode <= w_nanode;
      r_dp_n  <= w_ndp_n;
      r_tick  <= w_ntick;
    end
  end

  assign digit      = r_digit;
  assign shown_num  = r_shown;
  assign anode      = r_anode;
  assign dp_n       = r_dp_n;
  assign frame_tick = r_tick;
endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_display_scan_controller;
  logic        clk = 1'b0;
  logic        rst, en, lz_blank;
  logic [15:0] hex_num_4digit;
  logic [3:0]  digit_en, dp_in;
  logic [1:0]  digit;
  logic [15:0] shown_num;
  logic [3:0]  anode;
  logic        dp_n, frame_tick;

  typedef struct {
    string       name;
    logic [1:0]  digit;
    logic [3:0]  anode;
    logic        dp_n;
    logic        tick;
    logic [15:0] shown;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  display_scan_controller #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .hex_num_4digit (hex_num_4digit),
    .digit_en       (digit_en),
    .dp_in          (dp_in),
    .lz_blank       (lz_blank),
    .digit          (digit),
    .shown_num      (shown_num),
    .anode          (anode),
    .dp_n           (dp_n),
    .frame_tick     (frame_tick)
  );

  always #5 clk = ~clk;

  // Monitor: compares outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (digit !== e.digit || anode !== e.anode || dp_n !== e.dp_n ||
          frame_tick !== e.tick || shown_num !== e.shown) begin
        errors++;
        $display("FAIL %s: got digit=%0d anode=%b dp_n=%b tick=%b shown=%h, want digit=%0d anode=%b dp_n=%b tick=%b shown=%h",
                 e.name, digit, anode, dp_n, frame_tick, shown_num,
                 e.digit, e.anode, e.dp_n, e.tick, e.shown);
      end
    end
  end

  // Advance one clock and queue what the outputs must be for this cycle.
  task automatic cyc(input string nm, input logic [1:0] d, input logic [3:0] an,
                     input logic dp, input logic tk, input logic [15:0] sh);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = nm; e.digit = d; e.anode = an; e.dp_n = dp; e.tick = tk; e.shown = sh;
    q.push_back(e);
  endtask

  // One full slot: 2 guard cycles then 6 on-time cycles.
  task automatic slot(input string nm, input logic [1:0] d, input logic [3:0] an,
                      input logic dp, input logic tk, input logic [15:0] sh);
    cyc(nm, d, 4'hF, 1'b1, tk, sh);
    cyc(nm, d, 4'hF, 1'b1, 1'b0, sh);
    for (int i = 0; i < 6; i++) cyc(nm, d, an, dp, 1'b0, sh);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; lz_blank = 1'b0;
    hex_num_4digit = 16'hBEEF; digit_en = 4'hF; dp_in = 4'hF;
    cyc("reset", 2'd0, 4'hF, 1'b1, 1'b0, 16'h0000);
    cyc("reset", 2'd0, 4'hF, 1'b1, 1'b0, 16'h0000);
    en = 1'b0; dp_in = 4'h0;
    cyc("reset_hold", 2'd0, 4'hF, 1'b1, 1'b0, 16'h0000);
    rst = 1'b0;
    cyc("idle", 2'd0, 4'hF, 1'b1, 1'b0, 16'h0000);

    // Basic scan of 1234, two frames.
    hex_num_4digit = 16'h1234; en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      slot("scan_d0", 2'd0, 4'b1110, 1'b1, 1'b1, 16'h1234);
      slot("scan_d1", 2'd1, 4'b1101, 1'b1, 1'b0, 16'h1234);
      slot("scan_d2", 2'd2, 4'b1011, 1'b1, 1'b0, 16'h1234);
      slot("scan_d3", 2'd3, 4'b0111, 1'b1, 1'b0, 16'h1234);
    end
    en = 1'b0;
    cyc("en_off", 2'd0, 4'hF, 1'b1, 1'b0, 16'h1234);

    // Leading-zero blanking of 0050.
    hex_num_4digit = 16'h0050; lz_blank = 1'b1; en = 1'b1;
    slot("lz50_d0", 2'd0, 4'b1110, 1'b1, 1'b1, 16'h0050);
    slot("lz50_d1", 2'd1, 4'b1101, 1'b1, 1'b0, 16'h0050);
    slot("lz50_d2", 2'd2, 4'b1111, 1'b1, 1'b0, 16'h0050);
    slot("lz50_d3", 2'd3, 4'b1111, 1'b1, 1'b0, 16'h0050);
    en = 1'b0;
    cyc("en_off", 2'd0, 4'hF, 1'b1, 1'b0, 16'h0050);

    // All zero: only digit 0 lit.
    hex_num_4digit = 16'h0000; en = 1'b1;
    slot("lz00_d0", 2'd0, 4'b1110, 1'b1, 1'b1, 16'h0000);
    slot("lz00_d1", 2'd1, 4'b1111, 1'b1, 1'b0, 16'h0000);
    slot("lz00_d2", 2'd2, 4'b1111, 1'b1, 1'b0, 16'h0000);
    slot("lz00_d3", 2'd3, 4'b1111, 1'b1, 1'b0, 16'h0000);
    en = 1'b0;
    cyc("en_off", 2'd0, 4'hF, 1'b1, 1'b0, 16'h0000);

    // Value changed mid-frame only takes effect at the next frame boundary.
    hex_num_4digit = 16'h1111; lz_blank = 1'b0; en = 1'b1;
    slot("snap_d0", 2'd0, 4'b1110, 1'b1, 1'b1, 16'h1111);
    cyc("snap_d1", 2'd1, 4'hF, 1'b1, 1'b0, 16'h1111);
    cyc("snap_d1", 2'd1, 4'hF, 1'b1, 1'b0, 16'h1111);
    cyc("snap_d1", 2'd1, 4'b1101, 1'b1, 1'b0, 16'h1111);
    cyc("snap_d1", 2'd1, 4'b1101, 1'b1, 1'b0, 16'h1111);
    hex_num_4digit = 16'h2222;
    for (int i = 0; i < 4; i++) cyc("snap_d1", 2'd1, 4'b1101, 1'b1, 1'b0, 16'h1111);
    slot("snap_d2", 2'd2, 4'b1011, 1'b1, 1'b0, 16'h1111);
    slot("snap_d3", 2'd3, 4'b0111, 1'b1, 1'b0, 16'h1111);
    slot("snap_new", 2'd0, 4'b1110, 1'b1, 1'b1, 16'h2222);
    en = 1'b0;
    cyc("en_off", 2'd0, 4'hF, 1'b1, 1'b0, 16'h2222);

    // Decimal point and disabled digit 2.
    hex_num_4digit = 16'h1234; dp_in = 4'b0100; digit_en = 4'b1011; en = 1'b1;
    slot("dpoff_d0", 2'd0, 4'b1110, 1'b1, 1'b1, 16'h1234);
    slot("dpoff_d1", 2'd1, 4'b1101, 1'b1, 1'b0, 16'h1234);
    slot("dpoff_d2", 2'd2, 4'b1111, 1'b1, 1'b0, 16'h1234);
    slot("dpoff_d3", 2'd3, 4'b0111, 1'b1, 1'b0, 16'h1234);
    digit_en = 4'hF;
    slot("dp_d0", 2'd0, 4'b1110, 1'b1, 1'b1, 16'h1234);
    slot("dp_d1", 2'd1, 4'b1101, 1'b1, 1'b0, 16'h1234);
    // en dropped mid digit-2 SHOW.
    cyc("dp_d2", 2'd2, 4'hF, 1'b1, 1'b0, 16'h1234);
    cyc("dp_d2", 2'd2, 4'hF, 1'b1, 1'b0, 16'h1234);
    for (int i = 0; i < 3; i++) cyc("dp_d2", 2'd2, 4'b1011, 1'b0, 1'b0, 16'h1234);
    en = 1'b0;
    cyc("en_drop", 2'd0, 4'hF, 1'b1, 1'b0, 16'h1234);
    cyc("en_drop", 2'd0, 4'hF, 1'b1, 1'b0, 16'h1234);
    en = 1'b1;
    slot("restart_d0", 2'd0, 4'b1110, 1'b1, 1'b1, 16'h1234);
    slot("restart_d1", 2'd1, 4'b1101, 1'b1, 1'b0, 16'h1234);
    slot("restart_d2", 2'd2, 4'b1011, 1'b0, 1'b0, 16'h1234);
    // rst mid digit-3 SHOW.
    cyc("pre_rst_d3", 2'd3, 4'hF, 1'b1, 1'b0, 16'h1234);
    cyc("pre_rst_d3", 2'd3, 4'hF, 1'b1, 1'b0, 16'h1234);
    cyc("pre_rst_d3", 2'd3, 4'b0111, 1'b1, 1'b0, 16'h1234);
    cyc("pre_rst_d3", 2'd3, 4'b0111, 1'b1, 1'b0, 16'h1234);
    rst = 1'b1;
    cyc("mid_rst", 2'd0, 4'hF, 1'b1, 1'b0, 16'h0000);
    cyc("mid_rst", 2'd0, 4'hF, 1'b1, 1'b0, 16'h0000);
    rst = 1'b0;
    slot("post_rst_d0", 2'd0, 4'b1110, 1'b1, 1'b1, 16'h1234);
    slot("post_rst_d1", 2'd1, 4'b1101, 1'b1, 1'b0, 16'h1234);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
